// File: rtl/apb_pkg.sv
// Shared types for the APB master controller: FSM states, buffered request layout, default widths.
// The request struct is sized by the constants here; keep them equal to the top-level width parameters.
package apb_pkg;
  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_NSLV   = 3;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
    logic [APB_NSLV-1:0]   sel;
  } apb_req_t;
endpackage

// File: rtl/apb_master_ctrl_if.sv
// AHB-side request/response and APB bus signals of the APB master controller.
// master modport is the controller's view; slave modport is the surrounding system's view.
interface apb_master_ctrl_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int NSLV   = APB_NSLV
);
  logic              valid;
  logic              hwrite;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [NSLV-1:0]   tempselx;
  logic              hreadyout;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [NSLV-1:0]   pselx;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic              pready;
  logic              pslverr;
  logic [DATA_W-1:0] prdata;

  modport master (
    input  valid, hwrite, haddr, hwdata, tempselx, pready, pslverr, prdata,
    output hreadyout, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output valid, hwrite, haddr, hwdata, tempselx, pready, pslverr, prdata,
    input  hreadyout, rsp_valid, rsp_rdata, rsp_err, pselx, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_req_buf.sv
// One-entry request holding register; loads on valid && hreadyout, drains when the FSM issues SETUP.
// hreadyout is low while the entry is full or a read is outstanding; it depends on registers only.
module apb_req_buf
  import apb_pkg::*;
#(
  parameter int ADDR_W = APB_ADDR_W,
  parameter int DATA_W = APB_DATA_W,
  parameter int NSLV   = APB_NSLV
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              hwrite_i,
  input  logic [ADDR_W-1:0] haddr_i,
  input  logic [DATA_W-1:0] hwdata_i,
  input  logic [NSLV-1:0]   tempselx_i,
  input  logic              drain_i,
  input  logic              rd_done_i,
  output logic              full_o,
  output logic              hreadyout_o,
  output apb_req_t          req_o
);
  logic     buf_full_q, buf_full_d;
  logic     rd_pend_q, rd_pend_d;
  apb_req_t req_q, req_d;
  logic     accept;

  assign hreadyout_o = !buf_full_q && !rd_pend_q;
  assign accept      = valid_i && hreadyout_o;
  assign full_o      = buf_full_q;
  assign req_o       = req_q;

  always_comb begin
    buf_full_d = buf_full_q;
    rd_pend_d  = rd_pend_q;
    req_d      = req_q;
    if (drain_i) buf_full_d = 1'b0;
    if (rd_done_i) rd_pend_d = 1'b0;
    if (accept) begin
      buf_full_d  = 1'b1;
      rd_pend_d   = !hwrite_i;
      req_d.write = hwrite_i;
      req_d.addr  = APB_ADDR_W'(haddr_i);
      req_d.wdata = APB_DATA_W'(hwdata_i);
      req_d.sel   = APB_NSLV'(tempselx_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_full_q <= 1'b0;
      rd_pend_q  <= 1'b0;
      req_q      <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      rd_pend_q  <= rd_pend_d;
      req_q      <= req_d;
    end
  end
endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: one buffered AHB-side request, posted writes, blocking reads, PREADY waits, PSLVERR, timeout.
// Acceptance at edge N gives SETUP at N+1, ACCESS at N+2, and a zero-wait rsp_valid at N+3.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int NSLV    = APB_NSLV,
  parameter int TIMEOUT = 16
) (
  input logic               hclk,
  input logic               hreset,
  apb_master_ctrl_if.master bus
);
  localparam int              TMO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  apb_state_e        state_q;
  logic [NSLV-1:0]   pselx_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic [TMO_W-1:0]  tmo_q;

  logic     buf_full, buf_hready;
  apb_req_t buf_req;
  logic     tmo_hit, xfer_done, drain, rd_done;

  // The timeout fires on the TIMEOUT-th ACCESS cycle with pready still low.
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TMO_LAST);
  assign xfer_done = (state_q == ACCESS) && (bus.pready || tmo_hit);
  assign drain     = buf_full && ((state_q == IDLE) || xfer_done);
  assign rd_done   = xfer_done && !pwrite_q;

  apb_req_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NSLV   (NSLV)
  ) u_req_buf (
    .clk_i       (hclk),
    .rst_i       (hreset),
    .valid_i     (bus.valid),
    .hwrite_i    (bus.hwrite),
    .haddr_i     (bus.haddr),
    .hwdata_i    (bus.hwdata),
    .tempselx_i  (bus.tempselx),
    .drain_i     (drain),
    .rd_done_i   (rd_done),
    .full_o      (buf_full),
    .hreadyout_o (buf_hready),
    .req_o       (buf_req)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= IDLE;
      pselx_q     <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (buf_full) state_q <= SETUP;
        end
        SETUP: begin
          penable_q <= 1'b1;
          tmo_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (xfer_done) begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.pready ? bus.pslverr : 1'b1;
            rsp_rdata_q <= (bus.pready && !pwrite_q) ? bus.prdata : '0;
            penable_q   <= 1'b0;
            if (buf_full) begin
              state_q <= SETUP;
            end else begin
              pselx_q <= '0;
              state_q <= IDLE;
            end
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
      // SETUP entry loads the APB address phase from the buffer; it then holds through ACCESS.
      if (drain) begin
        pselx_q  <= NSLV'(buf_req.sel);
        pwrite_q <= buf_req.write;
        paddr_q  <= ADDR_W'(buf_req.addr);
        pwdata_q <= DATA_W'(buf_req.wdata);
      end
    end
  end

  assign bus.hreadyout = buf_hready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.pselx     = pselx_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: reset/idle, single write, waited read with error,
// back-to-back writes, read timeout, and reset during ACCESS with a buffered write.
module tb_apb_master_ctrl;
  logic hclk = 1'b0;
  logic hreset;
  int   checks = 0;
  int   errors = 0;

  always #5 hclk = ~hclk;

  apb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32), .NSLV(3)) bus ();

  apb_master_ctrl #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .NSLV    (3),
    .TIMEOUT (16)
  ) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  function automatic logic [31:0] b2b_addr(input int j);
    return 32'h0000_0100 + 32'(4 * j);
  endfunction

  function automatic logic [31:0] b2b_data(input int j);
    return 32'hC0DE_0000 + 32'(j);
  endfunction

  initial begin
    int acc_cycles;
    int rsp_seen;

    hreset = 1'b1;
    bus.valid = 1'b0; bus.hwrite = 1'b0; bus.haddr = '0; bus.hwdata = '0; bus.tempselx = '0;
    bus.pready = 1'b1; bus.pslverr = 1'b0; bus.prdata = '0;
    tick(); tick();
    chk("rst_hreadyout", bus.hreadyout, 1);
    chk("rst_pselx", bus.pselx, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    hreset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_hreadyout", bus.hreadyout, 1);
      chk("idle_pselx", bus.pselx, 0);
      chk("idle_penable", bus.penable, 0);
      chk("idle_rsp_valid", bus.rsp_valid, 0);
    end

    // Single zero-wait write
    bus.valid = 1'b1; bus.hwrite = 1'b1; bus.haddr = 32'h8000_0010; bus.hwdata = 32'hA5A5_5A5A;
    bus.tempselx = 3'b010; bus.pready = 1'b1; bus.pslverr = 1'b0;
    tick();
    bus.valid = 1'b0;
    chk("wr_n_hreadyout", bus.hreadyout, 0);
    chk("wr_n_pselx", bus.pselx, 0);
    tick();
    chk("wr_setup_pselx", bus.pselx, 3'b010);
    chk("wr_setup_penable", bus.penable, 0);
    chk("wr_setup_pwrite", bus.pwrite, 1);
    chk("wr_setup_paddr", bus.paddr, 32'h8000_0010);
    chk("wr_setup_pwdata", bus.pwdata, 32'hA5A5_5A5A);
    tick();
    chk("wr_access_penable", bus.penable, 1);
    chk("wr_access_pselx", bus.pselx, 3'b010);
    chk("wr_access_rsp_valid", bus.rsp_valid, 0);
    tick();
    chk("wr_done_rsp_valid", bus.rsp_valid, 1);
    chk("wr_done_rsp_err", bus.rsp_err, 0);
    chk("wr_done_rsp_rdata", bus.rsp_rdata, 0);
    chk("wr_done_pselx", bus.pselx, 0);
    chk("wr_done_penable", bus.penable, 0);
    tick();
    chk("wr_after_rsp_valid", bus.rsp_valid, 0);

    // Read with three wait states and a slave error
    bus.valid = 1'b1; bus.hwrite = 1'b0; bus.haddr = 32'h8000_0020; bus.tempselx = 3'b001;
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
    tick();
    bus.valid = 1'b0;
    chk("rd_n_hreadyout", bus.hreadyout, 0);
    tick();
    chk("rd_setup_pselx", bus.pselx, 3'b001);
    chk("rd_setup_pwrite", bus.pwrite, 0);
    chk("rd_setup_paddr", bus.paddr, 32'h8000_0020);
    chk("rd_setup_hreadyout", bus.hreadyout, 0);
    tick();
    chk("rd_acc1_penable", bus.penable, 1);
    tick();
    tick();
    tick();
    chk("rd_acc4_penable", bus.penable, 1);
    chk("rd_acc4_rsp_valid", bus.rsp_valid, 0);
    chk("rd_acc4_hreadyout", bus.hreadyout, 0);
    bus.pready = 1'b1; bus.prdata = 32'h1234_5678; bus.pslverr = 1'b1;
    tick();
    chk("rd_done_rsp_valid", bus.rsp_valid, 1);
    chk("rd_done_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
    chk("rd_done_rsp_err", bus.rsp_err, 1);
    chk("rd_done_hreadyout", bus.hreadyout, 1);
    chk("rd_done_pselx", bus.pselx, 0);
    bus.pslverr = 1'b0; bus.prdata = '0;
    tick();
    chk("rd_after_rsp_valid", bus.rsp_valid, 0);

    // Four back-to-back zero-wait writes: acceptances at edges 0,2,4,6
    for (int k = 0; k <= 9; k++) begin
      if ((k % 2 == 0) && (k <= 6)) begin
        bus.valid = 1'b1; bus.hwrite = 1'b1; bus.tempselx = 3'b100;
        bus.haddr = b2b_addr(k / 2); bus.hwdata = b2b_data(k / 2);
      end else begin
        bus.valid = 1'b0;
      end
      tick();
      if (k == 0) begin
        chk("b2b_e0_hreadyout", bus.hreadyout, 0);
        chk("b2b_e0_pselx", bus.pselx, 0);
      end else if (k == 9) begin
        chk("b2b_end_rsp_valid", bus.rsp_valid, 1);
        chk("b2b_end_pselx", bus.pselx, 0);
        chk("b2b_end_penable", bus.penable, 0);
        chk("b2b_end_hreadyout", bus.hreadyout, 1);
      end else if (k % 2 == 1) begin
        chk("b2b_setup_pselx", bus.pselx, 3'b100);
        chk("b2b_setup_penable", bus.penable, 0);
        chk("b2b_setup_paddr", bus.paddr, b2b_addr((k - 1) / 2));
        chk("b2b_setup_pwdata", bus.pwdata, b2b_data((k - 1) / 2));
        chk("b2b_setup_hreadyout", bus.hreadyout, 1);
        chk("b2b_setup_rsp_valid", bus.rsp_valid, (k >= 3) ? 1 : 0);
      end else begin
        chk("b2b_access_pselx", bus.pselx, 3'b100);
        chk("b2b_access_penable", bus.penable, 1);
        chk("b2b_access_paddr", bus.paddr, b2b_addr((k - 2) / 2));
        chk("b2b_access_pwdata", bus.pwdata, b2b_data((k - 2) / 2));
        chk("b2b_access_hreadyout", bus.hreadyout, (k <= 6) ? 0 : 1);
        chk("b2b_access_rsp_valid", bus.rsp_valid, 0);
      end
    end
    tick();

    // Read that never sees pready: timeout after 16 ACCESS cycles
    bus.valid = 1'b1; bus.hwrite = 1'b0; bus.haddr = 32'h8000_0030; bus.tempselx = 3'b001;
    bus.pready = 1'b0; bus.prdata = 32'hDEAD_BEEF; bus.pslverr = 1'b0;
    tick();
    bus.valid = 1'b0;
    tick();
    chk("tmo_setup_pselx", bus.pselx, 3'b001);
    acc_cycles = 0;
    rsp_seen = 0;
    for (int i = 0; (i < 40) && (rsp_seen == 0); i++) begin
      if (bus.penable === 1'b1) acc_cycles++;
      tick();
      if (bus.rsp_valid === 1'b1) rsp_seen = 1;
    end
    chk("tmo_rsp_seen", 64'(rsp_seen), 1);
    chk("tmo_access_cycles", 64'(acc_cycles), 16);
    chk("tmo_rsp_err", bus.rsp_err, 1);
    chk("tmo_rsp_rdata", bus.rsp_rdata, 0);
    chk("tmo_pselx", bus.pselx, 0);
    chk("tmo_penable", bus.penable, 0);
    chk("tmo_hreadyout", bus.hreadyout, 1);
    bus.pready = 1'b1; bus.prdata = '0;
    tick();

    // Reset during ACCESS with a second write sitting in the buffer
    bus.valid = 1'b1; bus.hwrite = 1'b1; bus.haddr = 32'h0000_00A0; bus.hwdata = 32'h1111_1111;
    bus.tempselx = 3'b010; bus.pready = 1'b0;
    tick();
    bus.haddr = 32'h0000_00B0; bus.hwdata = 32'h2222_2222; bus.tempselx = 3'b100;
    tick();
    chk("rstx_setup_hreadyout", bus.hreadyout, 1);
    tick();
    bus.valid = 1'b0;
    chk("rstx_access_penable", bus.penable, 1);
    chk("rstx_access_hreadyout", bus.hreadyout, 0);
    chk("rstx_access_paddr", bus.paddr, 32'h0000_00A0);
    hreset = 1'b1;
    tick();
    chk("rstx_pselx", bus.pselx, 0);
    chk("rstx_penable", bus.penable, 0);
    chk("rstx_rsp_valid", bus.rsp_valid, 0);
    chk("rstx_hreadyout", bus.hreadyout, 1);
    hreset = 1'b0;
    bus.pready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstx_post_pselx", bus.pselx, 0);
      chk("rstx_post_rsp_valid", bus.rsp_valid, 0);
      chk("rstx_post_paddr", bus.paddr, 0);
      chk("rstx_post_hreadyout", bus.hreadyout, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

Parametrised APB master controller sitting between the AHB slave interface (address/data pipeline registers and slave decode) and the APB peripheral bus. It accepts one AHB-side request at a time into a one-entry holding buffer. Writes are posted; reads stall the AHB side until data returns. It supports PREADY wait states, PSLVERR and a programmable access timeout, and generalises the fixed-width, three-select, zero-wait-state controller to N slaves of arbitrary address and data width.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NSLV, 3, number of APB slaves (width of one-hot select)
- TIMEOUT, 16, maximum ACCESS cycles with pready low before abort; 0 disables the timeout

Ports:
- hclk  in  1  clock. One clock; reset is synchronous and active-high.
- hreset  in  1  reset, synchronous, active-high
- valid  in  1  AHB-side request present
- hwrite  in  1  request direction, 1 = write
- haddr  in  ADDR_W  request address
- hwdata  in  DATA_W  write data, valid with valid
- tempselx  in  NSLV  one-hot slave select from decode
- hreadyout  out  1  request may be accepted this cycle
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes and aborts
- rsp_err  out  1  pslverr or timeout, valid with rsp_valid
- pselx  out  NSLV  APB select, one-hot or zero
- penable, pwrite  out  1  APB strobes
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- pready, pslverr  in  1  APB slave handshake
- prdata  in  DATA_W  APB read data

## Operation
- Acceptance: valid && hreadyout at a rising edge latches {hwrite, haddr, hwdata, tempselx} into the buffer (buf_full = 1).
- A read acceptance also sets rd_pend.
- hreadyout = !buf_full && !rd_pend, decoded from registers only; no combinational path from valid.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when buf_full. APB outputs load from the buffer and buf_full clears in the same edge.
  - SETUP -> ACCESS unconditionally. Sets penable = 1.
  - ACCESS, pready = 1: completes. Go to SETUP if buf_full (back-to-back, no idle bubble), else IDLE.
  - ACCESS, pready = 0: stay; the timeout counter increments.
- Completion: rsp_valid = 1 for one cycle. rsp_err = pslverr sampled with pready. rsp_rdata = prdata for reads, else 0. A read completion clears rd_pend.
- Timeout: if pready is still low on the TIMEOUT-th consecutive ACCESS cycle, the transfer ends as completion with rsp_err = 1 and rsp_rdata = 0. The counter clears on every SETUP. Counter width is $clog2(TIMEOUT+1).
- pselx, paddr, pwrite and pwdata stay stable from SETUP through the final ACCESS cycle.
- In IDLE: pselx = 0 and penable = 0. paddr, pwdata and pwrite hold their last values.
- tempselx that is zero or not one-hot: the transfer still runs with pselx as given. A zero select completes only by timeout. TIMEOUT = 0 with zero select hangs, which is accepted by design.

## Timing
- Reset values: pselx 0, penable 0, pwrite 0, paddr 0, pwdata 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, hreadyout 1. Buffer, rd_pend, FSM (IDLE) and timeout counter all clear.
- Reset mid-transfer: APB strobes drop at the reset edge, the buffered request is discarded, and no rsp_valid is issued.
- Latency, with acceptance at edge N and the FSM in IDLE:
  - SETUP is visible after edge N+1.
  - ACCESS is visible after edge N+2.
  - With zero wait states, rsp_valid is high after edge N+3.
- Write throughput: while a write is in ACCESS, the next write is accepted into the buffer. Steady state is 2 cycles per zero-wait write.
- A read blocks further acceptance until the cycle after its rsp_valid (hreadyout returns high with rsp_valid).
- Same edge as ACCESS completion with buf_full: the new SETUP is issued and the buffer drains. The buffer can refill on the next edge at the earliest.

## Structure
- Shared package apb_pkg holds:
  - the state enum apb_state_e {IDLE, SETUP, ACCESS}
  - the request struct apb_req_t {write, addr, wdata, sel}, parametrised via the package's width constants
  - the default ADDR_W/DATA_W constants
- Natural sub-module: apb_req_buf, the one-entry holding register with load/drain/full and hreadyout generation. The FSM, timeout counter and response logic stay in the top module.

## Test plan
- Reset, then idle for 10 cycles -> hreadyout = 1, pselx = 0, penable = 0, rsp_valid never asserted.
- Single write, haddr 0x8000_0010, hwdata 0xA5A5_5A5A, tempselx 3'b010, pready tied 1 -> SETUP after edge N+1 with pselx 010 and pwrite 1; ACCESS after edge N+2; rsp_valid after edge N+3 with rsp_err 0.
- Read from 0x8000_0020 with pready held low 3 cycles, prdata 0x1234_5678, pslverr 1 -> hreadyout low from acceptance; rsp_rdata 0x1234_5678 and rsp_err 1 with rsp_valid; hreadyout high with rsp_valid.
- Four back-to-back writes, zero wait -> no IDLE between transfers, one write completes every 2 cycles, paddr/pwdata stable through each SETUP+ACCESS.
- Read with pready never asserted, TIMEOUT = 16 -> exactly 16 ACCESS cycles, then rsp_valid with rsp_err 1 and rsp_rdata 0, pselx = 0 next cycle.
- hreset asserted during ACCESS with a write buffered -> strobes drop at the reset edge, no rsp_valid, hreadyout = 1 after reset, and the buffered write never appears on APB.
